// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM burst sequencer.
// EEPROM_BURST_VERIFY_EN adds the write read-back verify state.
package i2c_eeprom_pkg;

  localparam int unsigned BUF_DEPTH = 16;

`ifdef EEPROM_BURST_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrWait, StRdReq, StDone, StVrReq
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrWait, StRdReq, StDone
  } state_e;
`endif

  // EEPROM write-cycle time expressed in sys_clk cycles.
  function automatic int unsigned twr_cycles(input int unsigned clk_freq,
                                             input int unsigned twr_us);
    return clk_freq / 1_000_000 * twr_us;
  endfunction

endpackage

// File: rtl/i2c_eeprom_burst_if.sv
// Request/ack bus between the burst sequencer and i2c_master_top.
interface i2c_eeprom_burst_if;
  logic        i2c_read_req;
  logic        i2c_read_req_ack;
  logic        i2c_write_req;
  logic        i2c_write_req_ack;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_read_data;
  logic        i2c_error;

  modport master (
    output i2c_read_req, i2c_write_req, i2c_slave_dev_addr, i2c_slave_reg_addr,
           i2c_write_data,
    input  i2c_read_req_ack, i2c_write_req_ack, i2c_read_data, i2c_error
  );

  modport slave (
    input  i2c_read_req, i2c_write_req, i2c_slave_dev_addr, i2c_slave_reg_addr,
           i2c_write_data,
    output i2c_read_req_ack, i2c_write_req_ack, i2c_read_data, i2c_error
  );
endinterface

// File: rtl/eeprom_burst_buf.sv
// 16x8 staging buffer: one write port, separate user and engine read ports.
module eeprom_burst_buf
  import i2c_eeprom_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr_user,
  output logic [7:0] rdata_user,
  input  logic [3:0] raddr_eng,
  output logic [7:0] rdata_eng
);

  logic [7:0] mem_q [BUF_DEPTH];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_user = mem_q[raddr_user];
  assign rdata_eng  = mem_q[raddr_eng];

endmodule

// File: rtl/i2c_eeprom_burst.sv
// Burst sequencer splitting multi-byte EEPROM transfers into single-byte I2C requests.
// Optional read-back verify of write bursts is enabled by EEPROM_BURST_VERIFY_EN.
module i2c_eeprom_burst
  import i2c_eeprom_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TWR_US   = 5000,
  parameter logic [7:0]  DEV_ADDR = 8'hA0
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [7:0]                cmd_addr,
  input  logic [4:0]                cmd_len,
  input  logic                      buf_we,
  input  logic [3:0]                buf_waddr,
  input  logic [7:0]                buf_wdata,
  input  logic [3:0]                buf_raddr,
  output logic [7:0]                buf_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  i2c_eeprom_burst_if.master        i2c
);

  localparam logic [31:0] TwrLoad = 32'(twr_cycles(CLK_FREQ, TWR_US) - 1);

  state_e      state_q;
  logic [7:0]  addr_q;
  logic [3:0]  idx_q;
  logic [4:0]  rem_q;
  logic [31:0] twr_q;
  logic        rd_req_q, wr_req_q, done_q, error_q, busy_q, ready_q;
  logic [7:0]  wdata_q;
`ifdef EEPROM_BURST_VERIFY_EN
  logic [7:0]  base_addr_q;
  logic [4:0]  base_len_q;
`endif

  logic [4:0] len_clamped;
  logic       accept, wr_ack, rd_ack, eng_we, buf_wr;
  logic [7:0] eng_rdata;

  assign len_clamped = (cmd_len > 5'd16) ? 5'd16 : cmd_len;
  assign accept      = cmd_valid & ready_q;
  assign wr_ack      = wr_req_q & i2c.i2c_write_req_ack;
  assign rd_ack      = rd_req_q & i2c.i2c_read_req_ack;
  // Engine writes only on a clean read ack; verify reads never touch the buffer.
  assign eng_we      = (state_q == StRdReq) & rd_ack & ~i2c.i2c_error;
  assign buf_wr      = eng_we | (buf_we & (state_q == StIdle));

  eeprom_burst_buf u_buf (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .we         (buf_wr),
    .waddr      (eng_we ? idx_q : buf_waddr),
    .wdata      (eng_we ? i2c.i2c_read_data : buf_wdata),
    .raddr_user (buf_raddr),
    .rdata_user (buf_rdata),
    .raddr_eng  (idx_q),
    .rdata_eng  (eng_rdata)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= 8'h00;
      idx_q    <= 4'h0;
      rem_q    <= 5'd0;
      twr_q    <= 32'd0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      wdata_q  <= 8'h00;
`ifdef EEPROM_BURST_VERIFY_EN
      base_addr_q <= 8'h00;
      base_len_q  <= 5'd0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            addr_q  <= cmd_addr;
            idx_q   <= 4'h0;
            rem_q   <= len_clamped;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef EEPROM_BURST_VERIFY_EN
            base_addr_q <= cmd_addr;
            base_len_q  <= len_clamped;
`endif
            if (len_clamped == 5'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= cmd_write ? StWrReq : StRdReq;
            end
          end
        end
        StWrReq: begin
          if (!wr_req_q) begin
            wr_req_q <= 1'b1;
            wdata_q  <= eng_rdata;
          end else if (i2c.i2c_write_req_ack) begin
            wr_req_q <= 1'b0;
            if (i2c.i2c_error) begin
              error_q <= 1'b1;
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              twr_q   <= TwrLoad;
              state_q <= StWrWait;
            end
          end
        end
        StWrWait: begin
          if (twr_q != 32'd0) begin
            twr_q <= twr_q - 32'd1;
          end else begin
            addr_q <= addr_q + 8'd1;
            idx_q  <= idx_q + 4'd1;
            rem_q  <= rem_q - 5'd1;
            if (rem_q == 5'd1) begin
`ifdef EEPROM_BURST_VERIFY_EN
              addr_q  <= base_addr_q;
              idx_q   <= 4'h0;
              rem_q   <= base_len_q;
              state_q <= StVrReq;
`else
              state_q <= StDone;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= StWrReq;
            end
          end
        end
        StRdReq: begin
          if (!rd_req_q) begin
            rd_req_q <= 1'b1;
          end else if (i2c.i2c_read_req_ack) begin
            rd_req_q <= 1'b0;
            if (i2c.i2c_error) begin
              error_q <= 1'b1;
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + 8'd1;
              idx_q  <= idx_q + 4'd1;
              rem_q  <= rem_q - 5'd1;
              if (rem_q == 5'd1) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
        end
`ifdef EEPROM_BURST_VERIFY_EN
        StVrReq: begin
          if (!rd_req_q) begin
            rd_req_q <= 1'b1;
          end else if (i2c.i2c_read_req_ack) begin
            rd_req_q <= 1'b0;
            if (i2c.i2c_error || (i2c.i2c_read_data != eng_rdata)) begin
              error_q <= 1'b1;
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + 8'd1;
              idx_q  <= idx_q + 4'd1;
              rem_q  <= rem_q - 5'd1;
              if (rem_q == 5'd1) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready              = ready_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign error                  = error_q;
  assign i2c.i2c_read_req       = rd_req_q;
  assign i2c.i2c_write_req      = wr_req_q;
  assign i2c.i2c_slave_dev_addr = DEV_ADDR;
  assign i2c.i2c_slave_reg_addr = {8'h00, addr_q};
  assign i2c.i2c_write_data     = wdata_q;

endmodule

// File: doc/i2c_eeprom_burst.md
# i2c_eeprom_burst

Multi-byte EEPROM transfer sequencer sitting directly upstream of `i2c_master_top`: it accepts a burst command (start address, length, direction) and breaks it into single-byte read or write requests on the master's req/ack interface. Bytes are staged in an internal 16-byte buffer loaded or unloaded by the user. After every byte write it waits the EEPROM write-cycle time (tWR) before the next request. This replaces hand-written per-byte FSMs in board test tops.

## Interface
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `TWR_US`, 5000: write-cycle wait in µs after each byte write.
- `DEV_ADDR`, 8'hA0: driven on `i2c_slave_dev_addr`.
- `sys_clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: burst command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 8: first EEPROM byte address.
- `cmd_len` in 5: byte count; 0 = no transfer, values >16 clamp to 16.
- `buf_we` in 1: user buffer write strobe; ignored while busy.
- `buf_waddr` in 4, `buf_wdata` in 8: user buffer write port.
- `buf_raddr` in 4, `buf_rdata` out 8: user buffer read port; combinational read.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at end of burst.
- `error` out 1: valid with `done`; held until the next accepted command.
- `i2c_read_req` out 1, `i2c_read_req_ack` in 1: read handshake.
- `i2c_write_req` out 1, `i2c_write_req_ack` in 1: write handshake.
- `i2c_slave_dev_addr` out 8: device address.
- `i2c_slave_reg_addr` out 16: upper byte 0, lower byte = current address.
- `i2c_write_data` out 8: data byte to write.
- `i2c_read_data` in 8: data byte returned by a read.
- `i2c_error` in 1: master NACK/error flag, sampled with the ack.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, DONE, plus VR_REQ when the verify feature is compiled in.
- **IDLE:** on `cmd_valid & cmd_ready`:
  - latch `cmd_addr` into the address counter.
  - latch the clamped length into the remaining counter and clear the index.
  - clear `error`.
  - go to WR_REQ (write) or RD_REQ (read).
  - `cmd_len` = 0 goes straight to DONE.
- **WR_REQ:**
  - assert `i2c_write_req` with `i2c_write_data` = buf[index].
  - on ack: drop the req, load the tWR counter with CLK_FREQ/1_000_000*TWR_US−1 (249_999 at defaults), go to WR_WAIT.
- **WR_WAIT:**
  - count down; at 0, increment address (8-bit wrap FF→00) and index, decrement remaining.
  - remaining 0 → DONE (or VR_REQ with the verify feature, after reloading address, index and remaining).
  - otherwise → WR_REQ.
- **RD_REQ:**
  - assert `i2c_read_req`.
  - on ack: buf[index] ← `i2c_read_data`, then advance address, index and remaining.
  - remaining 0 → DONE, otherwise stay and re-assert the req.
- **Master error:** `i2c_error` high at any ack sets `error` and goes to DONE immediately, abandoning the remaining bytes.
- **DONE:** pulse `done` for one cycle, return to IDLE.
- **Buffer:**
  - a user `buf_we` in IDLE writes the buffer.
  - reads during a burst return the old contents until the engine overwrites them.

## Timing
- Reset values: `cmd_ready`=0 for the reset cycle, then 1 from the first clock in IDLE.
- All other outputs reset to 0, except `i2c_slave_dev_addr`=DEV_ADDR. Buffer contents reset to 0.
- Handshake:
  - req rises the cycle after the FSM enters a REQ state.
  - req stays high until ack is seen and falls on the next edge.
  - the ack cycle itself is the data-capture cycle.
- Between consecutive read bytes, req is low for exactly one cycle.
- Command acceptance to first req: 1 cycle. Last ack (or tWR expiry) to `done`: 1 cycle.
- `rst_n` low mid-burst returns to IDLE asynchronously and drops req immediately; the master is reset by the same signal.

## Configuration
- `EEPROM_BURST_VERIFY_EN` defined:
  - a write burst is followed by a read-back of every byte, compared against the buffer.
  - the first mismatch sets `error` and ends at DONE.
  - the buffer is not overwritten during verify.
- `EEPROM_BURST_VERIFY_EN` undefined: VR_REQ does not exist and a write burst ends after the last tWR.

## Structure
- Shared package `i2c_eeprom_pkg`:
  - state encoding.
  - `BUF_DEPTH`=16.
  - `TWR_CYCLES` function of CLK_FREQ and TWR_US.
- One sub-module, `eeprom_burst_buf`: 16×8 RAM with one write port (muxed user/engine) and two read ports (user/engine).

## Test plan
- **Write then read:** load buf[0..3]=11,22,33,44; write burst addr 0x10, len 4 → 4 write reqs with reg_addr 0x10..0x13, ≥250_000 cycles between reqs, `done` with `error`=0. Then read burst same range from a slave model → buf reads 11,22,33,44.
- **Address wrap:** read burst addr 0xFE, len 3 → reg_addr 0xFE, 0xFF, 0x00.
- **Length boundaries:** len 0 → `done` 1 cycle after accept, no req. len 20 → exactly 16 reqs.
- **Error abort:** `i2c_error` asserted with the 2nd ack of a 5-byte read → `done` with `error`=1, only 2 reqs issued.
- **Reset mid-burst:** assert `rst_n` low while `i2c_write_req` is high → req=0 immediately, `busy`=0, buffer=0, `cmd_ready`=1 after release.
- **Verify (`EEPROM_BURST_VERIFY_EN`):** slave model returns 0x45 for a byte written as 0x44 → `error`=1 at `done`.
